// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: Q5.10 fixed-point sample and collector FSM states.
package cnn_pkg;

  typedef logic signed [15:0] fixed_t;

  localparam int FRAC_BITS = 10;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1
  } collect_state_t;

endpackage

// File: rtl/pool_map_index_counter.sv
// Write-index counter for the pooled map; flags the beat that completes the frame.
module pool_map_index_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] r_count;

  // clr wins over inc so a restart never leaves a stale index behind
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign count = r_count;
  assign last  = inc && (r_count == CW'(DEPTH - 1));

endmodule

// File: rtl/pool_map_collector.sv
// Collects the serial max-pool output into an MxM register map and hands it
// to the next layer with a valid/ack handshake, holding it stable until acked.
module pool_map_collector
  import cnn_pkg::*;
#(
  parameter  int N     = 4,
  localparam int M     = N / 2,
  localparam int DEPTH = M * M,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic signed [15:0]  in_data,
  output logic                in_ready,
  output logic signed [15:0]  map [0:DEPTH-1],
  output logic                map_valid,
  input  logic                map_ack,
  output logic [CW-1:0]       count,
  output logic                overflow
);

  collect_state_t r_state;
  fixed_t         r_map [0:DEPTH-1];
  logic           r_overflow;

  logic           w_accept;
  logic           w_clr;
  logic           w_last;
  logic           w_dropped;
  logic [CW-1:0]  w_count;

  // start outranks everything: a beat alongside it is neither stored nor counted as dropped
  assign w_accept  = in_valid && (r_state == FILL) && !start;
  assign w_dropped = in_valid && (r_state == FULL) && !start;
  assign w_clr     = start || ((r_state == FULL) && map_ack);

  pool_map_index_counter #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_index (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_accept),
    .count (w_count),
    .last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FILL;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_map[i] <= '0;
      end
    end else begin
      if (start) begin
        r_state <= FILL;
      end else if ((r_state == FULL) && map_ack) begin
        r_state <= FILL;
      end else if (w_last) begin
        r_state <= FULL;
      end

      if (w_dropped) begin
        r_overflow <= 1'b1;
      end

      // map is only ever overwritten, never cleared, outside reset
      for (int i = 0; i < DEPTH; i++) begin
        if (w_accept && (w_count == CW'(i))) begin
          r_map[i] <= in_data;
        end
      end
    end
  end

  assign in_ready  = (r_state == FILL);
  assign map_valid = (r_state == FULL);
  assign map       = r_map;
  assign count     = w_count;
  assign overflow  = r_overflow;

endmodule
